// File: rtl/fft_frame_counter_pkg.sv
// Shared types and helpers for the FFT frame counter.
// Holds the FSM state encoding and the channel-index width function.
package fft_ctr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2
    } state_t;

    // A single channel still needs a 1-bit index port.
    function automatic int chan_w(input int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Tracks sample/channel/frame indices of a channel-interleaved FFT output stream after a delayed sync.
// Latency: first countable beat is 1+sync_delay cycles after the sync cycle; frame_done lags the last beat by 1.
// Backpressure: none; advances only on sample_valid beats, holds otherwise.
module fft_frame_counter
    import fft_ctr_pkg::*;
#(
    parameter int SAMPLES      = 2048,
    parameter int CHANNELS     = 1,
    parameter int FRAMES_W     = 8,
    parameter int SYNC_DELAY_W = 4,
    parameter int CONTINUOUS   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fft_sync,
    input  logic                          clr_cnt,
    input  logic                          sample_valid,
    input  logic [SYNC_DELAY_W-1:0]       sync_delay,
    output logic [$clog2(SAMPLES)-1:0]    count,
    output logic [chan_w(CHANNELS)-1:0]   chan,
    output logic [FRAMES_W-1:0]           frame_num,
    output logic                          counting,
    output logic                          frame_first,
    output logic                          frame_last,
    output logic                          frame_done,
    output logic                          overrun
);

    localparam int CNT_W = $clog2(SAMPLES);
    localparam int CH_W  = chan_w(CHANNELS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLES - 1);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CHANNELS - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [SYNC_DELAY_W-1:0] r_delay_cnt;
    logic [CNT_W-1:0]        r_count;
    logic [CH_W-1:0]         r_chan;
    logic [FRAMES_W-1:0]     r_frame_num;
    logic                    r_frame_done;
    logic                    r_overrun;

    logic w_clr;
    logic w_beat;
    logic w_chan_wrap;
    logic w_last;
    logic w_rearm;
    logic w_ovr_set;

    assign w_clr       = rst | clr_cnt;
    assign w_beat      = (r_state == COUNT) && sample_valid;
    assign w_chan_wrap = (r_chan == CH_MAX);
    assign w_last      = w_beat && w_chan_wrap && (r_count == CNT_MAX);
    // A one-shot frame ending this cycle frees the counter, so a coincident sync re-arms it.
    assign w_rearm     = fft_sync && ((r_state == IDLE) || (w_last && (CONTINUOUS == 0)));
    assign w_ovr_set   = fft_sync && !w_rearm;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (fft_sync) begin
                    w_next = (sync_delay == '0) ? COUNT : ARMED;
                end
            end
            ARMED: begin
                if (r_delay_cnt <= SYNC_DELAY_W'(1)) begin
                    w_next = COUNT;
                end
            end
            COUNT: begin
                if (w_last && (CONTINUOUS == 0)) begin
                    if (w_rearm) begin
                        w_next = (sync_delay == '0) ? COUNT : ARMED;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_delay_cnt  <= '0;
            r_count      <= '0;
            r_chan       <= '0;
            r_frame_num  <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (w_rearm) begin
                r_delay_cnt <= sync_delay;
            end else if (r_state == ARMED) begin
                r_delay_cnt <= r_delay_cnt - SYNC_DELAY_W'(1);
            end
            // SAMPLES is a power of two, so the count rolls over to 0 on the last beat by itself.
            if (w_beat) begin
                if (w_chan_wrap) begin
                    r_chan  <= '0;
                    r_count <= r_count + CNT_W'(1);
                end else begin
                    r_chan  <= r_chan + CH_W'(1);
                end
            end
            if (w_last) begin
                r_frame_num <= r_frame_num + FRAMES_W'(1);
            end
        end
    end

    always_comb begin
        counting    = (r_state == COUNT);
        frame_first = w_beat && (r_count == '0) && (r_chan == '0);
        frame_last  = w_last;
        count       = r_count;
        chan        = r_chan;
        frame_num   = r_frame_num;
        frame_done  = r_frame_done;
        overrun     = r_overrun;
    end

endmodule
